// File: rtl/rv_pipe_pkg.sv
// Shared pipeline definitions for the RV front end: data width, the bubble
// instruction used by IF and the IF/ID register, and the fetch FSM states.
package rv_pipe_pkg;

  localparam int unsigned XLEN = 32;

  // andi x0,x0,0 -- architecturally a no-op, used wherever a bubble is needed.
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_7013;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    VALID   = 2'd2,
    DISCARD = 2'd3
  } fetch_state_t;

endpackage : rv_pipe_pkg

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: owns the PC, runs a req/ack handshake to
// instruction memory and presents {pc, instr, valid} to the IF/ID register.
// A redirect that races an outstanding request parks the FSM in DISCARD so
// the stale response is swallowed rather than presented.
module if_fetch_unit
  import rv_pipe_pkg::XLEN, rv_pipe_pkg::fetch_state_t,
         rv_pipe_pkg::IDLE, rv_pipe_pkg::FETCH,
         rv_pipe_pkg::VALID, rv_pipe_pkg::DISCARD;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = rv_pipe_pkg::NOP_INSTR
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_stall,
  input  logic            i_redirect,
  input  logic [XLEN-1:0] i_redirect_pc,
  output logic            o_imem_req,
  output logic [XLEN-1:0] o_imem_addr,
  input  logic            i_imem_ack,
  input  logic [XLEN-1:0] i_imem_rdata,
  output logic [XLEN-1:0] o_if_pc,
  output logic [XLEN-1:0] o_if_instr,
  output logic            o_if_valid
);

  fetch_state_t    state, state_next;
  logic [XLEN-1:0] pc, pc_next;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] out_pc, out_instr;
  logic            out_valid;

  logic            enter_fetch;   // req_addr reloads from pc_next this edge
  logic            capture;       // latch the memory response into the outputs
  logic            retire;        // presented instruction leaves the outputs

  logic [XLEN-1:0] redirect_tgt;
  logic [XLEN-1:0] pc_inc;

  // Targets are always word aligned; the low two bits are simply discarded.
  assign redirect_tgt = {i_redirect_pc[XLEN-1:2], 2'b00};
  wire   unused_redirect_lsbs = ^i_redirect_pc[1:0];

  // Wraps modulo 2^32 by construction of the 32-bit add.
  assign pc_inc = pc + 32'd4;

  // Next-state, next-pc and output-update strobes for the fetch FSM.
  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_next  = state;
    pc_next     = pc;
    enter_fetch = 1'b0;
    capture     = 1'b0;
    retire      = 1'b0;
    unique case (state)
      IDLE: begin
        state_next  = FETCH;
        enter_fetch = 1'b1;
      end
      FETCH: begin
        if (i_imem_ack && !i_redirect) begin
          state_next = VALID;
          capture    = 1'b1;
        end else if (i_imem_ack && i_redirect) begin
          // Response arrived together with the redirect: drop it and refetch.
          pc_next     = redirect_tgt;
          enter_fetch = 1'b1;
        end else if (i_redirect) begin
          // Request still in flight at the old address; wait it out.
          pc_next    = redirect_tgt;
          state_next = DISCARD;
        end
      end
      VALID: begin
        if (i_redirect) begin
          pc_next     = redirect_tgt;
          state_next  = FETCH;
          enter_fetch = 1'b1;
          retire      = 1'b1;
        end else if (!i_stall) begin
          pc_next     = pc_inc;
          state_next  = FETCH;
          enter_fetch = 1'b1;
          retire      = 1'b1;
        end
      end
      DISCARD: begin
        // Later redirects simply overwrite the pending target.
        if (i_redirect) begin
          pc_next = redirect_tgt;
        end
        if (i_imem_ack) begin
          state_next  = FETCH;
          enter_fetch = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, pc, request address and presented-instruction registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      req_addr  <= RESET_PC;
      out_pc    <= RESET_PC;
      out_instr <= NOP_INSTR;
      out_valid <= 1'b0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      if (enter_fetch) begin
        req_addr <= pc_next;
      end
      if (capture) begin
        out_pc    <= req_addr;
        out_instr <= i_imem_rdata;
        out_valid <= 1'b1;
      end else if (retire) begin
        out_instr <= NOP_INSTR;
        out_valid <= 1'b0;
      end
    end
  end

  // Request is decoded from state so an asynchronous reset drops it at once.
  assign o_imem_req  = (state == FETCH) || (state == DISCARD);
  assign o_imem_addr = req_addr;
  assign o_if_pc     = out_pc;
  assign o_if_instr  = out_instr;
  assign o_if_valid  = out_valid;

endmodule : if_fetch_unit

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit. Inputs are driven and outputs sampled on
// the falling clock edge, so every check sees the state left by the previous
// rising edge and every stimulus is set up half a cycle before it is used.
module tb_if_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_7013;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_stall;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_ack;
  logic [31:0] i_imem_rdata;
  logic [31:0] o_if_pc;
  logic [31:0] o_if_instr;
  logic        o_if_valid;

  int checks = 0;
  int errors = 0;

  if_fetch_unit dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_stall       (i_stall),
    .i_redirect    (i_redirect),
    .i_redirect_pc (i_redirect_pc),
    .o_imem_req    (o_imem_req),
    .o_imem_addr   (o_imem_addr),
    .i_imem_ack    (i_imem_ack),
    .i_imem_rdata  (i_imem_rdata),
    .o_if_pc       (o_if_pc),
    .o_if_instr    (o_if_instr),
    .o_if_valid    (o_if_valid)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Presented-instruction triple.
  task automatic chk_out(input string tag, input logic v, input logic [31:0] pc,
                         input logic [31:0] instr);
    check({tag, ".valid"}, {31'd0, o_if_valid}, {31'd0, v});
    check({tag, ".pc"},    o_if_pc,    pc);
    check({tag, ".instr"}, o_if_instr, instr);
  endtask

  // Memory request; the address is only meaningful while req is high.
  task automatic chk_req(input string tag, input logic r, input logic [31:0] addr);
    check({tag, ".req"}, {31'd0, o_imem_req}, {31'd0, r});
    if (r) check({tag, ".addr"}, o_imem_addr, addr);
  endtask

  task automatic cyc();
    @(negedge i_clk);
  endtask

  initial begin
    i_reset = 1'b1; i_stall = 1'b0; i_redirect = 1'b0; i_redirect_pc = '0;
    i_imem_ack = 1'b0; i_imem_rdata = '0;
    cyc(); cyc();
    chk_out("reset", 1'b0, 32'h0, NOP);
    chk_req("reset", 1'b0, 32'h0);

    // ---- boot, zero-latency ack ----
    i_reset = 1'b0;
    cyc();                                  // IDLE -> FETCH
    chk_req("boot0", 1'b1, 32'h0);
    chk_out("boot0", 1'b0, 32'h0, NOP);
    i_imem_ack = 1'b1; i_imem_rdata = 32'h0010_0013;
    cyc(); i_imem_ack = 1'b0;
    chk_out("pres0", 1'b1, 32'h0, 32'h0010_0013);
    chk_req("pres0", 1'b0, 32'h0);
    cyc();
    chk_out("gap0", 1'b0, 32'h0, NOP);
    chk_req("boot4", 1'b1, 32'h4);
    i_imem_ack = 1'b1; i_imem_rdata = 32'h0020_0013;
    cyc(); i_imem_ack = 1'b0;
    chk_out("pres4", 1'b1, 32'h4, 32'h0020_0013);
    cyc();
    chk_out("gap4", 1'b0, 32'h4, NOP);
    chk_req("boot8", 1'b1, 32'h8);
    i_imem_ack = 1'b1; i_imem_rdata = 32'h0030_0013;
    cyc(); i_imem_ack = 1'b0;
    chk_out("pres8", 1'b1, 32'h8, 32'h0030_0013);

    // ---- three-cycle memory latency at 0xC ----
    cyc();
    chk_req("lat1", 1'b1, 32'hC);
    chk_out("lat1", 1'b0, 32'h8, NOP);
    cyc();
    chk_req("lat2", 1'b1, 32'hC);
    cyc();
    chk_req("lat3", 1'b1, 32'hC);
    chk_out("lat3", 1'b0, 32'h8, NOP);
    i_imem_ack = 1'b1; i_imem_rdata = 32'h0050_0093;
    cyc(); i_imem_ack = 1'b0;
    chk_out("presC", 1'b1, 32'hC, 32'h0050_0093);

    // ---- stall hold for four edges ----
    i_stall = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk_out($sformatf("stall%0d", k), 1'b1, 32'hC, 32'h0050_0093);
      chk_req($sformatf("stall%0d", k), 1'b0, 32'h0);
    end
    i_stall = 1'b0;
    cyc();
    chk_req("unstall", 1'b1, 32'h10);
    chk_out("unstall", 1'b0, 32'hC, NOP);

    // ---- redirect while request at 0x10 is outstanding ----
    i_redirect = 1'b1; i_redirect_pc = 32'h100;
    cyc(); i_redirect = 1'b0;
    chk_req("disc0", 1'b1, 32'h10);
    chk_out("disc0", 1'b0, 32'hC, NOP);
    cyc();
    chk_req("disc1", 1'b1, 32'h10);
    i_imem_ack = 1'b1; i_imem_rdata = 32'hDEAD_BEEF;
    cyc(); i_imem_ack = 1'b0;
    chk_out("disc_drop", 1'b0, 32'hC, NOP);
    chk_req("disc_refetch", 1'b1, 32'h100);

    // ---- redirect coincident with ack in FETCH ----
    i_imem_ack = 1'b1; i_imem_rdata = 32'h1111_1111;
    i_redirect = 1'b1; i_redirect_pc = 32'h200;
    cyc(); i_imem_ack = 1'b0; i_redirect = 1'b0;
    chk_out("ackredir", 1'b0, 32'hC, NOP);
    chk_req("ackredir", 1'b1, 32'h200);
    i_imem_ack = 1'b1; i_imem_rdata = 32'h0020_8133;
    cyc(); i_imem_ack = 1'b0;
    chk_out("pres200", 1'b1, 32'h200, 32'h0020_8133);

    // ---- redirect + stall in VALID, misaligned target 0x103 ----
    i_stall = 1'b1; i_redirect = 1'b1; i_redirect_pc = 32'h103;
    cyc(); i_redirect = 1'b0;
    chk_out("redirstall", 1'b0, 32'h200, NOP);
    chk_req("redirstall", 1'b1, 32'h100);
    // stall is still high but has no effect in FETCH
    i_imem_ack = 1'b1; i_imem_rdata = 32'h0000_0513;
    cyc(); i_imem_ack = 1'b0;
    chk_out("pres100", 1'b1, 32'h100, 32'h0000_0513);
    i_stall = 1'b0;
    cyc();
    chk_req("seq104", 1'b1, 32'h104);

    // ---- reset asserted mid-DISCARD ----
    i_redirect = 1'b1; i_redirect_pc = 32'h300;
    cyc(); i_redirect = 1'b0;
    chk_req("predisc", 1'b1, 32'h104);
    #2 i_reset = 1'b1;
    #1;
    chk_req("asyncrst", 1'b0, 32'h0);
    chk_out("asyncrst", 1'b0, 32'h0, NOP);
    cyc();
    // stray ack while IDLE must not be taken
    i_reset = 1'b0; i_imem_ack = 1'b1; i_imem_rdata = 32'hBAD0_0BAD;
    cyc(); i_imem_ack = 1'b0;
    chk_out("idleack", 1'b0, 32'h0, NOP);
    chk_req("idleack", 1'b1, 32'h0);

    // ---- wrap at the top of the address space ----
    i_redirect = 1'b1; i_redirect_pc = 32'hFFFF_FFFC;
    cyc(); i_redirect = 1'b0;
    chk_req("wrapdisc", 1'b1, 32'h0);
    i_imem_ack = 1'b1; i_imem_rdata = 32'h5555_5555;
    cyc(); i_imem_ack = 1'b0;
    chk_req("wrapfetch", 1'b1, 32'hFFFF_FFFC);
    chk_out("wrapfetch", 1'b0, 32'h0, NOP);
    i_imem_ack = 1'b1; i_imem_rdata = 32'h0040_0113;
    cyc(); i_imem_ack = 1'b0;
    chk_out("presTop", 1'b1, 32'hFFFF_FFFC, 32'h0040_0113);
    cyc();
    chk_req("wrapped", 1'b1, 32'h0);
    chk_out("wrapped", 1'b0, 32'hFFFF_FFFC, NOP);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_if_fetch_unit
